// File: rtl/vga_pkg.sv
// Shared timing types, standard VGA modes and the per-axis total helper.
// Timing fields are FW bits wide; the generator's CW must not exceed FW.
package vga_pkg;

    localparam int FW = 16;

    typedef struct packed {
        logic [FW-1:0] sync;
        logic [FW-1:0] back;
        logic [FW-1:0] disp;
        logic [FW-1:0] front;
    } vga_axis_t;

    typedef struct packed {
        vga_axis_t h;
        vga_axis_t v;
    } vga_timing_t;

    localparam vga_timing_t VGA_640x480_60 = '{
        h: '{sync: 16'd96,  back: 16'd48,  disp: 16'd640,  front: 16'd16},
        v: '{sync: 16'd2,   back: 16'd33,  disp: 16'd480,  front: 16'd10}
    };

    localparam vga_timing_t VGA_1024x768_60 = '{
        h: '{sync: 16'd136, back: 16'd160, disp: 16'd1024, front: 16'd24},
        v: '{sync: 16'd6,   back: 16'd29,  disp: 16'd768,  front: 16'd3}
    };

    // Two guard bits so four full-width fields cannot overflow.
    function automatic logic [FW+1:0] axis_total(vga_axis_t a);
        return {2'b00, a.sync} + {2'b00, a.back} + {2'b00, a.disp} + {2'b00, a.front};
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Configuration port of the timing generator: load strobe, fields, status.
interface vga_timing_gen_if #(parameter int CW = 11);
    logic          cfg_load;
    logic [CW-1:0] cfg_h_sync, cfg_h_back, cfg_h_disp, cfg_h_front;
    logic [CW-1:0] cfg_v_sync, cfg_v_back, cfg_v_disp, cfg_v_front;
    logic          cfg_pending;
    logic          cfg_err;

    modport master (
        output cfg_load,
        output cfg_h_sync, cfg_h_back, cfg_h_disp, cfg_h_front,
        output cfg_v_sync, cfg_v_back, cfg_v_disp, cfg_v_front,
        input  cfg_pending, cfg_err
    );

    modport slave (
        input  cfg_load,
        input  cfg_h_sync, cfg_h_back, cfg_h_disp, cfg_h_front,
        input  cfg_v_sync, cfg_v_back, cfg_v_disp, cfg_v_front,
        output cfg_pending, cfg_err
    );
endinterface

// File: rtl/vga_timing_gen_axis_ctr.sv
// One raster axis: wrapping counter plus sync / display / request-window decode.
module vga_axis_ctr
    import vga_pkg::*;
#(
    parameter int CW   = 11,
    parameter int LEAD = 0
) (
    input  logic          vga_clk,
    input  logic          sys_rst_n,
    input  logic          adv,
    input  vga_axis_t     axis,
    output logic [CW-1:0] cnt,
    output logic          at_end,
    output logic          sync_act,
    output logic          win,
    output logic          req_win,
    output logic [CW-1:0] pos
);
    localparam int TW = FW + 2;

    logic [TW-1:0] c, win_lo, win_hi, req_lo, req_hi;

    assign c      = TW'(cnt);
    assign win_lo = TW'(axis.sync) + TW'(axis.back);
    assign win_hi = win_lo + TW'(axis.disp);
    // back >= LEAD is enforced at load time, so req_lo never underflows.
    assign req_lo = win_lo - TW'(LEAD);
    assign req_hi = win_hi - TW'(LEAD);

    assign at_end   = (c == axis_total(axis) - TW'(1));
    assign sync_act = (c < TW'(axis.sync));
    assign win      = (c >= win_lo) && (c < win_hi);
    assign req_win  = (c >= req_lo) && (c < req_hi);
    assign pos      = CW'(c - req_lo);

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)  cnt <= '0;
        else if (adv)    cnt <= at_end ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Runtime-reconfigurable VGA timing generator; new timing takes effect only
// at the last pixel of a frame so a frame is never mixed.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int          CW         = 11,
    parameter int          REQ_LEAD   = 1,
    parameter bit          HS_POL     = 1'b0,
    parameter bit          VS_POL     = 1'b0,
    parameter vga_timing_t DEF_TIMING = VGA_1024x768_60
) (
    input  logic               vga_clk,
    input  logic               sys_rst_n,
    vga_timing_gen_if.slave    cfg,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vga_en,
    output logic               data_req,
    output logic [CW-1:0]      pixel_xpos,
    output logic [CW-1:0]      pixel_ypos,
    output logic               frame_start,
    output logic               line_start
);
    localparam logic [FW+1:0] MAX_TOT = (FW+2)'(1) << CW;

    vga_timing_t act_t, shd_t, cfg_new;
    logic        cfg_ok, apply;
    logic [CW-1:0] h_cnt, v_cnt, h_pos, v_pos;
    logic        h_end, h_sync, h_win, h_req;
    logic        v_end, v_sync, v_win, v_req;

    assign cfg_new = '{
        h: '{FW'(cfg.cfg_h_sync), FW'(cfg.cfg_h_back), FW'(cfg.cfg_h_disp), FW'(cfg.cfg_h_front)},
        v: '{FW'(cfg.cfg_v_sync), FW'(cfg.cfg_v_back), FW'(cfg.cfg_v_disp), FW'(cfg.cfg_v_front)}
    };

    assign cfg_ok = (|cfg_new.h.sync) && (|cfg_new.h.back) && (|cfg_new.h.disp) && (|cfg_new.h.front)
                 && (|cfg_new.v.sync) && (|cfg_new.v.back) && (|cfg_new.v.disp) && (|cfg_new.v.front)
                 && (cfg_new.h.back >= FW'(REQ_LEAD))
                 && (axis_total(cfg_new.h) <= MAX_TOT)
                 && (axis_total(cfg_new.v) <= MAX_TOT);

    assign apply = h_end && v_end;

    vga_axis_ctr #(.CW(CW), .LEAD(REQ_LEAD)) u_h_ctr (
        .vga_clk, .sys_rst_n, .adv(1'b1), .axis(act_t.h),
        .cnt(h_cnt), .at_end(h_end), .sync_act(h_sync), .win(h_win), .req_win(h_req), .pos(h_pos)
    );

    vga_axis_ctr #(.CW(CW), .LEAD(0)) u_v_ctr (
        .vga_clk, .sys_rst_n, .adv(h_end), .axis(act_t.v),
        .cnt(v_cnt), .at_end(v_end), .sync_act(v_sync), .win(v_win), .req_win(v_req), .pos(v_pos)
    );

    // A load landing on the apply cycle queues behind the shadow being applied.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            act_t           <= DEF_TIMING;
            shd_t           <= DEF_TIMING;
            cfg.cfg_pending <= 1'b0;
            cfg.cfg_err     <= 1'b0;
        end else begin
            cfg.cfg_err <= 1'b0;
            if (apply) begin
                act_t           <= shd_t;
                cfg.cfg_pending <= 1'b0;
            end
            if (cfg.cfg_load) begin
                if (cfg_ok) begin
                    shd_t           <= cfg_new;
                    cfg.cfg_pending <= 1'b1;
                end else begin
                    cfg.cfg_err     <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vga_hs      <= ~HS_POL;
            vga_vs      <= ~VS_POL;
            vga_en      <= 1'b0;
            data_req    <= 1'b0;
            pixel_xpos  <= '0;
            pixel_ypos  <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            vga_hs      <= h_sync ? HS_POL : ~HS_POL;
            vga_vs      <= v_sync ? VS_POL : ~VS_POL;
            vga_en      <= h_win && v_win;
            data_req    <= h_req && v_req;
            pixel_xpos  <= (h_req && v_req) ? h_pos : '0;
            pixel_ypos  <= (h_req && v_req) ? v_pos : '0;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            line_start  <= (h_cnt == '0);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a raster reference model queues expected outputs each
// cycle; two instances cover REQ_LEAD=1/low syncs and REQ_LEAD=2/high syncs.
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int CW = 11;

    localparam vga_timing_t TB_DEF = '{h: '{16'd4, 16'd3, 16'd8, 16'd2}, v: '{16'd2, 16'd2, 16'd5, 16'd1}}; // 17x10
    localparam vga_timing_t TB_A   = '{h: '{16'd3, 16'd2, 16'd6, 16'd3}, v: '{16'd1, 16'd2, 16'd4, 16'd2}}; // 14x9
    localparam vga_timing_t TB_B   = '{h: '{16'd5, 16'd2, 16'd4, 16'd2}, v: '{16'd1, 16'd1, 16'd3, 16'd2}}; // 13x7
    localparam vga_timing_t TB_C   = '{h: '{16'd2, 16'd1, 16'd5, 16'd1}, v: '{16'd1, 16'd1, 16'd3, 16'd1}}; // 9x6

    typedef struct packed {
        logic hs, vs, en, req;
        logic [CW-1:0] x, y;
        logic fs, ls, pend, err;
    } obs_t;

    logic vga_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 vga_clk = ~vga_clk;

    vga_timing_gen_if #(.CW(CW)) cfg0 ();
    vga_timing_gen_if #(.CW(CW)) cfg1 ();

    logic [1:0]    hs, vs, en, req, fs, ls;
    logic [CW-1:0] xp [2];
    logic [CW-1:0] yp [2];

    vga_timing_gen #(.CW(CW), .REQ_LEAD(1), .HS_POL(1'b0), .VS_POL(1'b0), .DEF_TIMING(TB_DEF)) dut0 (
        .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .cfg(cfg0),
        .vga_hs(hs[0]), .vga_vs(vs[0]), .vga_en(en[0]), .data_req(req[0]),
        .pixel_xpos(xp[0]), .pixel_ypos(yp[0]), .frame_start(fs[0]), .line_start(ls[0])
    );

    vga_timing_gen #(.CW(CW), .REQ_LEAD(2), .HS_POL(1'b1), .VS_POL(1'b1), .DEF_TIMING(TB_DEF)) dut1 (
        .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .cfg(cfg1),
        .vga_hs(hs[1]), .vga_vs(vs[1]), .vga_en(en[1]), .data_req(req[1]),
        .pixel_xpos(xp[1]), .pixel_ypos(yp[1]), .frame_start(fs[1]), .line_start(ls[1])
    );

    int          n_chk = 0, n_fail = 0, cyc = 0, last_fs = -1;
    int          rh [2], rv [2];
    bit          pend [2];
    vga_timing_t act [2], shd [2];
    vga_timing_t drv;
    obs_t        sb [2][$];
    int          gap_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic int tot(vga_axis_t a);
        return int'(a.sync) + int'(a.back) + int'(a.disp) + int'(a.front);
    endfunction

    function automatic bit cfg_valid(vga_timing_t t, int ld);
        return t.h.sync != 0 && t.h.back != 0 && t.h.disp != 0 && t.h.front != 0
            && t.v.sync != 0 && t.v.back != 0 && t.v.disp != 0 && t.v.front != 0
            && int'(t.h.back) >= ld && tot(t.h) <= 2048 && tot(t.v) <= 2048;
    endfunction

    function automatic obs_t model_out(int i);
        obs_t o = '0;
        int   ld = (i == 0) ? 1 : 2;
        bit   pol = (i == 1);
        int   x0 = int'(act[i].h.sync) + int'(act[i].h.back);
        int   y0 = int'(act[i].v.sync) + int'(act[i].v.back);
        bit   on_line = rv[i] >= y0 && rv[i] < y0 + int'(act[i].v.disp);
        o.hs  = (rh[i] < int'(act[i].h.sync)) ? pol : !pol;
        o.vs  = (rv[i] < int'(act[i].v.sync)) ? pol : !pol;
        o.en  = on_line && rh[i] >= x0 && rh[i] < x0 + int'(act[i].h.disp);
        o.req = on_line && rh[i] + ld >= x0 && rh[i] + ld < x0 + int'(act[i].h.disp);
        if (o.req) begin
            o.x = CW'(rh[i] + ld - x0);
            o.y = CW'(rv[i] - y0);
        end
        o.fs = (rh[i] == 0 && rv[i] == 0);
        o.ls = (rh[i] == 0);
        return o;
    endfunction

    function automatic obs_t dut_out(int i);
        obs_t o;
        o.hs = hs[i]; o.vs = vs[i]; o.en = en[i]; o.req = req[i];
        o.x = xp[i]; o.y = yp[i]; o.fs = fs[i]; o.ls = ls[i];
        o.pend = (i == 0) ? cfg0.cfg_pending : cfg1.cfg_pending;
        o.err  = (i == 0) ? cfg0.cfg_err : cfg1.cfg_err;
        return o;
    endfunction

    function automatic bit at_end0();
        return rh[0] == tot(act[0].h) - 1 && rv[0] == tot(act[0].v) - 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            rh[i] = 0; rv[i] = 0; pend[i] = 0;
            act[i] = TB_DEF; shd[i] = TB_DEF;
        end
    endtask

    task automatic step();
        for (int i = 0; i < 2; i++) begin
            obs_t e  = model_out(i);
            bit   ld = (i == 0) && cfg0.cfg_load;
            bit   ap = (rh[i] == tot(act[i].h) - 1) && (rv[i] == tot(act[i].v) - 1);
            bit   np = pend[i];
            bit   ne = 1'b0;
            if (rh[i] == tot(act[i].h) - 1) begin
                rh[i] = 0;
                rv[i] = (rv[i] == tot(act[i].v) - 1) ? 0 : rv[i] + 1;
            end else begin
                rh[i]++;
            end
            if (ap) begin act[i] = shd[i]; np = 1'b0; end
            if (ld) begin
                if (cfg_valid(drv, 1)) begin shd[i] = drv; np = 1'b1; end
                else ne = 1'b1;
            end
            pend[i] = np;
            e.pend = np;
            e.err  = ne;
            sb[i].push_back(e);
        end
        @(posedge vga_clk);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            obs_t e = sb[i].pop_front();
            check($sformatf("outputs_dut%0d", i), 64'(dut_out(i)), 64'(e));
        end
        if (fs[0]) begin
            if (last_fs >= 0 && gap_q.size() > 0) check("frame_len", 64'(cyc - last_fs), 64'(gap_q.pop_front()));
            last_fs = cyc;
        end
    endtask

    task automatic drive_cfg(input vga_timing_t t);
        drv = t;
        cfg0.cfg_h_sync = CW'(t.h.sync); cfg0.cfg_h_back = CW'(t.h.back);
        cfg0.cfg_h_disp = CW'(t.h.disp); cfg0.cfg_h_front = CW'(t.h.front);
        cfg0.cfg_v_sync = CW'(t.v.sync); cfg0.cfg_v_back = CW'(t.v.back);
        cfg0.cfg_v_disp = CW'(t.v.disp); cfg0.cfg_v_front = CW'(t.v.front);
    endtask

    task automatic do_load(input vga_timing_t t);
        drive_cfg(t);
        cfg0.cfg_load = 1'b1;
        step();
        cfg0.cfg_load = 1'b0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        vga_timing_t t;
        obs_t r0, r1;
        cfg0.cfg_load = 1'b0;
        cfg1.cfg_load = 1'b0;
        drive_cfg(TB_DEF);
        cfg1.cfg_h_sync = '0; cfg1.cfg_h_back = '0; cfg1.cfg_h_disp = '0; cfg1.cfg_h_front = '0;
        cfg1.cfg_v_sync = '0; cfg1.cfg_v_back = '0; cfg1.cfg_v_disp = '0; cfg1.cfg_v_front = '0;
        r0 = '0; r0.hs = 1'b1; r0.vs = 1'b1;
        r1 = '0;
        model_reset();

        #12;
        check("reset_dut0", 64'(dut_out(0)), 64'(r0));
        check("reset_dut1", 64'(dut_out(1)), 64'(r1));
        sys_rst_n = 1'b1;

        // Frame 0 on reset timing, with loads of varied validity mid-frame.
        gap_q.push_back(170); gap_q.push_back(126); gap_q.push_back(91); gap_q.push_back(54);
        run(50);
        do_load(TB_A);
        check("pending_after_load", 64'(cfg0.cfg_pending), 64'd1);
        run(10);
        t = TB_A; t.h.disp = '0;
        do_load(t);
        check("err_zero_disp", 64'(cfg0.cfg_err), 64'd1);
        run(5);
        t = TB_A; t.h = '{16'd1024, 16'd1000, 16'd24, 16'd1};
        do_load(t);
        check("err_total_2049", 64'(cfg0.cfg_err), 64'd1);
        run(5);
        t = TB_A; t.h = '{16'd1024, 16'd1000, 16'd23, 16'd1};
        do_load(t);
        check("ok_total_2048", 64'(cfg0.cfg_err), 64'd0);
        run(5);
        do_load(TB_A);
        for (int k = 0; k < 400 && cfg0.cfg_pending; k++) step();
        check("pending_cleared", 64'(cfg0.cfg_pending), 64'd0);

        // Frame 1 on A; load B, then load C exactly on the apply cycle.
        run(20);
        do_load(TB_B);
        for (int k = 0; k < 300 && !at_end0(); k++) step();
        do_load(TB_C);
        check("pending_coincident", 64'(cfg0.cfg_pending), 64'd1);
        for (int k = 0; k < 400 && cfg0.cfg_pending; k++) step();
        check("pending_cleared_c", 64'(cfg0.cfg_pending), 64'd0);
        run(74);

        // Mid-line reset with a pending load: everything returns to reset values.
        do_load(TB_A);
        run(3);
        sys_rst_n = 1'b0;
        #2;
        check("midreset_dut0", 64'(dut_out(0)), 64'(r0));
        check("midreset_dut1", 64'(dut_out(1)), 64'(r1));
        model_reset();
        last_fs = -1;
        check("gaps_before_reset", 64'(gap_q.size()), 64'd0);
        gap_q.delete();
        gap_q.push_back(170); gap_q.push_back(170);
        #1;
        sys_rst_n = 1'b1;
        run(400);
        check("gaps_after_reset", 64'(gap_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
